// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX framer and its parity helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit generator over a data word; shared with the RX parity checker.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Even parity makes the total count of ones even; odd parity inverts it.
    always_comb begin
        par_bit = (par_typ == PAR_EVEN) ? ^data : ~^data;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Latency: start bit is on TX from the accept edge; TX and busy come straight from flops.
// Backpressure: requests are taken only in idle or on the last stop bit; others are dropped.
module uart_tx_framer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop_sel,
    output logic                  TX,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop_sel_q, stop_sel_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  accept;
    logic                  par_bit;

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );

    // Next state plus the TX/busy value that belongs to the state being entered,
    // so the registered outputs line up with the state on the same edge.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop_sel_d = stop_sel_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                accept = data_valid;
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
                tx_d      = data_q[0];
            end
            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    stop_cnt_d = 1'b0;
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    tx_d      = data_q[bit_cnt_d];
                end
            end
            PARITY: begin
                state_d    = STOP;
                stop_cnt_d = 1'b0;
                tx_d       = 1'b1;
            end
            STOP: begin
                tx_d = 1'b1;
                if (stop_sel_q && !stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    // Last stop bit ends here; a held request starts the next
                    // frame on this same edge with no extra idle cycle.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    accept  = data_valid;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (accept) begin
            state_d    = START;
            data_d     = p_data;
            par_en_d   = par_en;
            par_typ_d  = par_typ;
            stop_sel_d = stop_sel;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
        end
    end

    // State, latched frame configuration and output registers; reset abandons any frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop_sel_q <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop_sel_q <= stop_sel_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign TX   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer (8-bit and 5-bit instances).
// Latency: expects the start bit on TX at the accept edge.
// Backpressure: expects requests during a frame to be dropped, held ones taken at frame end.
module tb_uart_tx_framer;
    import uart_tx_pkg::*;

    logic       CLK;
    logic       RST;
    logic [7:0] p_data;
    logic       data_valid, par_en, par_typ, stop_sel;
    logic       TX, busy;

    logic [4:0] p_data5;
    logic       dv5, pe5, pt5, ss5;
    logic       tx5, busy5;

    int checks = 0;
    int errors = 0;

    uart_tx_framer #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .p_data(p_data), .data_valid(data_valid),
        .par_en(par_en), .par_typ(par_typ), .stop_sel(stop_sel),
        .TX(TX), .busy(busy)
    );

    uart_tx_framer #(.DATA_WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .p_data(p_data5), .data_valid(dv5),
        .par_en(pe5), .par_typ(pt5), .stop_sel(ss5),
        .TX(tx5), .busy(busy5)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        pt;
        logic        ss;
        logic [15:0] exp;
        int          len;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame built straight from the line format: start, data LSB first,
    // optional parity chosen so the ones count matches the parity type, stops.
    function automatic void model(input logic [7:0] d, input logic pe, input logic pt,
                                  input logic ss, output logic [15:0] bits, output int len);
        int n    = 0;
        int ones = 0;
        bits = '1;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (pe) begin
            bits[n] = (pt == PAR_ODD) ? (ones % 2 == 0) : (ones % 2 == 1);
            n++;
        end
        n += ss ? 2 : 1;
        len = n;
    endfunction

    // Called just after a negedge with the DUT idle; returns after the negedge following E0+len.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt, input logic ss,
                             input logic [15:0] exp, input int len, input string tag);
        p_data = d; par_en = pe; par_typ = pt; stop_sel = ss; data_valid = 1'b1;
        @(negedge CLK);
        data_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s tx[%0d]", tag, i), 32'(TX), 32'(exp[i]));
            chk($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'd1);
            p_data = 8'($urandom); par_en = 1'($urandom);
            par_typ = 1'($urandom); stop_sel = 1'($urandom);
            @(negedge CLK);
        end
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        chk({tag, " tx_end"}, 32'(TX), 32'd1);
    endtask

    initial begin
        logic [15:0] bits;
        int          len;
        int          gap;
        logic [7:0]  rd;
        logic        rpe, rpt, rss;

        vecs[0] = '{d: 8'hA5, pe: 1'b0, pt: 1'b0, ss: 1'b0, exp: 16'hFC00 | 16'b1101001010,   len: 10};
        vecs[1] = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, ss: 1'b1, exp: 16'hF000 | 16'b110101001010, len: 12};
        vecs[2] = '{d: 8'h01, pe: 1'b1, pt: 1'b1, ss: 1'b0, exp: 16'hF800 | 16'b10000000010,  len: 11};
        vecs[3] = '{d: 8'h03, pe: 1'b1, pt: 1'b1, ss: 1'b0, exp: 16'hF800 | 16'b11000000110,  len: 11};

        RST = 1'b0;
        p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0; stop_sel = 1'b0;
        p_data5 = '0; dv5 = 1'b0; pe5 = 1'b0; pt5 = 1'b0; ss5 = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset tx", 32'(TX), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset tx5", 32'(tx5), 32'd1);
        chk("reset busy5", 32'(busy5), 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle tx", 32'(TX), 32'd1);

        // Known frames from the table.
        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].d, vecs[v].pe, vecs[v].pt, vecs[v].ss,
                      vecs[v].exp, vecs[v].len, $sformatf("vec%0d", v));
            @(negedge CLK);
            chk($sformatf("vec%0d idle", v), 32'(TX), 32'd1);
        end

        // 0xFF frame: 0x55 pulsed during data bit 3 is dropped; held 0x55 starts at E0+L.
        model(8'hFF, 1'b0, 1'b0, 1'b0, bits, len);
        p_data = 8'hFF; par_en = 1'b0; par_typ = 1'b0; stop_sel = 1'b0; data_valid = 1'b1;
        @(negedge CLK);
        data_valid = 1'b0;
        for (int c = 0; c < len; c++) begin
            chk($sformatf("ff tx[%0d]", c), 32'(TX), 32'(bits[c]));
            chk($sformatf("ff busy[%0d]", c), 32'(busy), 32'd1);
            if (c == 3) begin
                p_data = 8'h55; data_valid = 1'b1;
            end else if (c == 4) begin
                data_valid = 1'b0;
            end else if (c == 7) begin
                data_valid = 1'b1;
            end
            @(negedge CLK);
        end
        data_valid = 1'b0;
        model(8'h55, 1'b0, 1'b0, 1'b0, bits, len);
        for (int c = 0; c < len; c++) begin
            chk($sformatf("b2b55 tx[%0d]", c), 32'(TX), 32'(bits[c]));
            chk($sformatf("b2b55 busy[%0d]", c), 32'(busy), 32'd1);
            @(negedge CLK);
        end
        chk("b2b55 busy_end", 32'(busy), 32'd0);
        chk("b2b55 tx_end", 32'(TX), 32'd1);
        @(negedge CLK);

        // Reset during the data phase abandons the frame immediately.
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop_sel = 1'b1; data_valid = 1'b1;
        @(negedge CLK);
        data_valid = 1'b0;
        chk("rst start tx", 32'(TX), 32'd0);
        repeat (3) @(negedge CLK);
        chk("rst mid busy", 32'(busy), 32'd1);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst edge tx", 32'(TX), 32'd1);
        chk("rst edge busy", 32'(busy), 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst after tx", 32'(TX), 32'd1);
        chk("rst after busy", 32'(busy), 32'd0);
        model(8'h3C, 1'b1, 1'b1, 1'b0, bits, len);
        run_frame(8'h3C, 1'b1, 1'b1, 1'b0, bits, len, "post_rst");
        @(negedge CLK);

        // 5-bit instance: 0x13 with even parity.
        begin
            logic [7:0] exp5;
            exp5 = 8'b11100110;
            p_data5 = 5'h13; pe5 = 1'b1; pt5 = PAR_EVEN; ss5 = 1'b0; dv5 = 1'b1;
            @(negedge CLK);
            dv5 = 1'b0;
            p_data5 = 5'h0A; pe5 = 1'b0; ss5 = 1'b1;
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("w5 tx[%0d]", c), 32'(tx5), 32'(exp5[c]));
                chk($sformatf("w5 busy[%0d]", c), 32'(busy5), 32'd1);
                @(negedge CLK);
            end
            chk("w5 busy_end", 32'(busy5), 32'd0);
            chk("w5 tx_end", 32'(tx5), 32'd1);
        end

        // Randomized frames against the model, with random idle gaps.
        for (int f = 0; f < 40; f++) begin
            rd = 8'($urandom); rpe = 1'($urandom); rpt = 1'($urandom); rss = 1'($urandom);
            model(rd, rpe, rpt, rss, bits, len);
            run_frame(rd, rpe, rpt, rss, bits, len, $sformatf("rnd%0d", f));
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge CLK);
                chk($sformatf("rnd%0d gap tx", f), 32'(TX), 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
